// File: rtl/shared_dmem_xbar.sv
// rtl/shared_dmem_xbar.sv - banked multi-port data memory with per-bank arbitration
// DMEM_RR_ARB_EN selects round-robin per bank; undefined gives fixed priority (lowest core wins).
module shared_dmem_xbar #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int NUM_BANKS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CORES-1:0]          req,
  input  logic [NUM_CORES-1:0]          we,
  input  logic [NUM_CORES*ADDR_W-1:0]   addr,
  input  logic [NUM_CORES*DATA_W-1:0]   wdata,
  output logic [NUM_CORES-1:0]          gnt,
  output logic [NUM_CORES-1:0]          rvalid,
  output logic [NUM_CORES*DATA_W-1:0]   rdata
);

  localparam int BANK_W     = $clog2(NUM_BANKS);
  localparam int BSEL_W     = (BANK_W > 0) ? BANK_W : 1;
  localparam int ROW_W      = ADDR_W - BANK_W;
  localparam int ROW_IW     = (ROW_W > 0) ? ROW_W : 1;
  localparam int BANK_DEPTH = 2 ** ROW_W;
  localparam int IDX_W      = $clog2(NUM_CORES);

  logic [DATA_W-1:0]                 mem_q [NUM_BANKS][BANK_DEPTH];
  logic [ADDR_W-1:0]                 core_addr [NUM_CORES];
  logic [BSEL_W-1:0]                 core_bank [NUM_CORES];
  logic [ROW_IW-1:0]                 core_row  [NUM_CORES];
  logic [NUM_BANKS-1:0]              bank_act;
  logic [IDX_W-1:0]                  bank_sel [NUM_BANKS];
  logic [NUM_CORES-1:0]              gnt_c;
  logic [NUM_CORES-1:0]              rvalid_q, rvalid_d;
  logic [NUM_CORES-1:0][DATA_W-1:0]  rdata_q, rdata_d;

  always_comb begin
    for (int k = 0; k < NUM_CORES; k++) begin
      core_addr[k] = addr[k*ADDR_W +: ADDR_W];
      core_bank[k] = BSEL_W'(core_addr[k] & ADDR_W'(NUM_BANKS - 1));
      core_row[k]  = ROW_IW'(core_addr[k] >> BANK_W);
    end
  end

`ifdef DMEM_RR_ARB_EN
  logic [IDX_W-1:0] ptr_q [NUM_BANKS];
  logic [IDX_W-1:0] ptr_d [NUM_BANKS];
`endif

  // Each bank scans the cores once, taking the first live requester for it.
  always_comb begin
    int idx;
    idx      = 0;
    bank_act = '0;
    gnt_c    = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_sel[b] = '0;
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int off = 0; off < NUM_CORES; off++) begin
`ifdef DMEM_RR_ARB_EN
        idx = (int'(ptr_q[b]) + off) % NUM_CORES;
`else
        idx = off;
`endif
        if (!bank_act[b] && !rst && req[idx] && (core_bank[idx] == BSEL_W'(b))) begin
          bank_act[b] = 1'b1;
          bank_sel[b] = IDX_W'(idx);
          gnt_c[idx]  = 1'b1;
        end
      end
    end
  end

`ifdef DMEM_RR_ARB_EN
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      ptr_d[b] = ptr_q[b];
      if (bank_act[b]) begin
        ptr_d[b] = IDX_W'((int'(bank_sel[b]) + 1) % NUM_CORES);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rst) begin
        ptr_q[b] <= '0;
      end else begin
        ptr_q[b] <= ptr_d[b];
      end
    end
  end
`endif

  always_comb begin
    rvalid_d = '0;
    rdata_d  = rdata_q;
    for (int k = 0; k < NUM_CORES; k++) begin
      rvalid_d[k] = gnt_c[k] & ~we[k];
      if (rvalid_d[k]) begin
        rdata_d[k] = mem_q[core_bank[k]][core_row[k]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage is deliberately not reset; bank_act is already false during rst.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_act[b] && we[bank_sel[b]]) begin
        mem_q[b][core_row[bank_sel[b]]] <= wdata[int'(bank_sel[b])*DATA_W +: DATA_W];
      end
    end
  end

  // A read returning in a reset cycle is hidden along with the held data.
  assign gnt    = gnt_c;
  assign rvalid = rst ? '0 : rvalid_q;
  assign rdata  = rst ? '0 : rdata_q;

endmodule

// File: tb/tb_shared_dmem_xbar.sv
// tb/tb_shared_dmem_xbar.sv - directed self-checking bench for shared_dmem_xbar
// Conflict expectations follow DMEM_RR_ARB_EN, the same macro the design build uses.
module tb_shared_dmem_xbar;

  localparam int NC = 4;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int NB = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC-1:0]     req, we;
  logic [NC*AW-1:0]  addr;
  logic [NC*DW-1:0]  wdata;
  logic [NC-1:0]     gnt, rvalid;
  logic [NC*DW-1:0]  rdata;

  int n_vec    = 0;
  int n_miscmp = 0;

  always #5 clk = ~clk;

  shared_dmem_xbar #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .NUM_BANKS(NB)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_core(input int k, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[k]           = r;
    we[k]            = w;
    addr[k*AW +: AW] = a;
    wdata[k*DW +: DW] = d;
  endtask

  task automatic idle();
    req = '0;
    we  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [DW-1:0] rd(input int k);
    return rdata[k*DW +: DW];
  endfunction

  logic [AW-1:0] pre_a [5];
  logic [DW-1:0] pre_d [5];
  logic [NC-1:0] exp_g [5];
  logic [NC-1:0] prev_g;
  int            gi;

  initial begin
    pre_a = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h20};
    pre_d = '{16'hA000, 16'hA004, 16'hA008, 16'hA00C, 16'h1234};
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rst = 1'b1;
    idle();
    addr  = '0;
    wdata = '0;
    for (int k = 0; k < NC; k++) set_core(k, 1'b1, 1'b0, AW'(k * 4), '0);

    // Reset held three cycles with every core requesting.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("rst_gnt", 64'(gnt), 64'h0);
      chk("rst_rvalid", 64'(rvalid), 64'h0);
      chk("rst_rdata", 64'(rdata), 64'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rel_gnt", 64'(gnt), 64'b0001);
    @(negedge clk);
    chk("rel_rvalid", 64'(rvalid), 64'b0001);
    idle();

    // Parallel writes then reads on four distinct banks.
    for (int k = 0; k < NC; k++) set_core(k, 1'b1, 1'b1, AW'(8'h10 + k), DW'(16'h1111 * (k + 1)));
    #1 chk("par_wr_gnt", 64'(gnt), 64'b1111);
    @(negedge clk);
    for (int k = 0; k < NC; k++) set_core(k, 1'b1, 1'b0, AW'(8'h10 + k), '0);
    #1 chk("par_rd_gnt", 64'(gnt), 64'b1111);
    chk("wr_no_rvalid", 64'(rvalid), 64'h0);
    @(negedge clk);
    chk("par_rvalid", 64'(rvalid), 64'b1111);
    chk("par_rdata", 64'(rdata), 64'h4444_3333_2222_1111);
    idle();
    @(negedge clk);
    chk("rvalid_pulse", 64'(rvalid), 64'h0);
    chk("rdata_hold", 64'(rdata), 64'h4444_3333_2222_1111);

    // Preload bank 0 through core 0 alone.
    for (int i = 0; i < 5; i++) begin
      set_core(0, 1'b1, 1'b1, pre_a[i], pre_d[i]);
      #1 chk("pre_gnt", 64'(gnt), 64'b0001);
      @(negedge clk);
    end
    idle();
    do_reset();

    // All cores contend continuously for bank 0.
    for (int k = 0; k < NC; k++) set_core(k, 1'b1, 1'b0, AW'(k * 4), '0);
`ifdef DMEM_RR_ARB_EN
    for (int i = 0; i < 5; i++) begin
      #1 chk("rr_gnt", 64'(gnt), 64'(exp_g[i]));
      prev_g = exp_g[i];
      gi     = i % NC;
      @(negedge clk);
      chk("rr_rvalid", 64'(rvalid), 64'(prev_g));
      chk("rr_rdata", 64'(rd(gi)), 64'(pre_d[gi]));
    end
`else
    for (int i = 0; i < 4; i++) begin
      #1 chk("fp_gnt", 64'(gnt), 64'b0001);
      @(negedge clk);
      chk("fp_rvalid", 64'(rvalid), 64'b0001);
      chk("fp_rdata", 64'(rd(0)), 64'hA000);
    end
    req[0] = 1'b0;
    #1 chk("fp_next_gnt", 64'(gnt), 64'b0010);
    @(negedge clk);
    chk("fp_next_rvalid", 64'(rvalid), 64'b0010);
    chk("fp_next_rdata", 64'(rd(1)), 64'hA004);
`endif
    idle();
    do_reset();

    // Same-address write by core 2 racing a read by core 1.
    set_core(2, 1'b1, 1'b1, 8'h20, 16'hBEEF);
    set_core(1, 1'b1, 1'b0, 8'h20, '0);
    #1 chk("raw_gnt0", 64'(gnt), 64'b0010);
    @(negedge clk);
    req[1] = 1'b0;
    #1 chk("raw_gnt1", 64'(gnt), 64'b0100);
    chk("raw_rvalid0", 64'(rvalid), 64'b0010);
    chk("raw_old", 64'(rd(1)), 64'h1234);
    @(negedge clk);
    req[2] = 1'b0;
    set_core(1, 1'b1, 1'b0, 8'h20, '0);
    #1 chk("raw_gnt2", 64'(gnt), 64'b0010);
    chk("raw_wr_norv", 64'(rvalid), 64'h0);
    @(negedge clk);
    idle();
    chk("raw_rvalid1", 64'(rvalid), 64'b0010);
    chk("raw_new", 64'(rd(1)), 64'hBEEF);

    // Reset lands in the cycle a read result is due.
    set_core(3, 1'b1, 1'b0, 8'h11, '0);
    #1 chk("mid_gnt", 64'(gnt), 64'b1000);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("mid_rvalid", 64'(rvalid), 64'h0);
    chk("mid_rdata", 64'(rd(3)), 64'h0);
    chk("mid_rst_gnt", 64'(gnt), 64'h0);
    @(negedge clk);
    chk("mid_rvalid2", 64'(rvalid), 64'h0);
    rst = 1'b0;
    #1 chk("post_gnt", 64'(gnt), 64'b1000);
    @(negedge clk);
    idle();
    chk("post_rvalid", 64'(rvalid), 64'b1000);
    chk("post_rdata", 64'(rd(3)), 64'h2222);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
